// File: rtl/fifo_rd_arbiter_pkg.sv
// Shared definitions for the dual-clock FIFO read side.
//   state_e       : read-arbiter FSM encoding (idle = 0, serve = 1)
//   PtrWDefault   : default pointer width, wrap bit included
//   BurstCntW     : width of the per-grant burst counter
//   depth_of()    : FIFO depth for a given pointer width
package fifo_rd_arbiter_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StServe = 1'b1
  } state_e;

  localparam int unsigned PtrWDefault = 9;
  localparam int unsigned BurstCntW   = 4;

  // The pointer carries one extra wrap bit above the address bits.
  function automatic int unsigned depth_of(input int unsigned ptr_w);
    return 32'd1 << (ptr_w - 1);
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
//   req        : request per requester
//   last_owner : index of the requester that held the previous grant
//   enable     : when low, nothing is picked
//   pick       : one-hot selected requester (zero when none)
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       enable,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   pick = 2'b01;
        2'b10:   pick = 2'b10;
        // Contention goes to whoever did not own the port last.
        2'b11:   pick = last_owner ? 2'b01 : 2'b10;
        default: pick = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Read-side controller of the dual-clock FIFO, read clock domain only.
// Computes fill level / empty from the synchronized write pointer, owns the
// read pointer, and shares the single memory read port between two
// requesters with round-robin grants of at most MAX_BURST reads each.
//   clk, rst    : read clock, synchronous active-high reset
//   wr_ptr_sync : binary write pointer already brought into this domain
//   req         : level-sensitive read requests
//   gnt         : registered one-hot owner
//   rd_en       : memory read strobe, rd_addr its address
//   rd_ptr      : registered binary read pointer (back to the synchronizer)
//   valid       : per-requester data valid, one cycle after rd_en
//   empty/level : fill state; ptr_err sticky flag for level > depth
module fifo_rd_arbiter
  import fifo_rd_arbiter_pkg::*;
#(
  parameter int unsigned PTR_W     = PtrWDefault,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PTR_W-1:0] wr_ptr_sync,
  input  logic [1:0]       req,
  output logic [1:0]       gnt,
  output logic             rd_en,
  output logic [PTR_W-2:0] rd_addr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [1:0]       valid,
  output logic             empty,
  output logic [PTR_W-1:0] level,
  output logic             ptr_err
);

  localparam logic [PTR_W-1:0]     DepthVal  = PTR_W'(depth_of(PTR_W));
  localparam logic [BurstCntW-1:0] MaxBurstV = BurstCntW'(MAX_BURST);

  state_e               state_q, state_d;
  logic [1:0]           gnt_q, gnt_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [BurstCntW-1:0] burst_q, burst_d, burst_inc;
  logic                 last_q, last_d;
  logic [1:0]           valid_q;
  logic                 ptr_err_q;
  logic                 over, blocked, owner, rd_go;
  logic [1:0]           pick;

  // Modulo subtraction makes wrap of either pointer transparent.
  assign level     = wr_ptr_sync - rd_ptr_q;
  assign empty     = (level == '0);
  assign over      = (level > DepthVal);
  // A corrupt pointer distance is treated like an empty FIFO.
  assign blocked   = empty | over;
  assign owner     = gnt_q[1];
  assign burst_inc = burst_q + 1'b1;

  rr_pick2 u_pick (
    .req        (req),
    .last_owner (last_q),
    .enable     ((state_q == StIdle) & ~blocked),
    .pick       (pick)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rd_ptr_d = rd_ptr_q;
    burst_d  = burst_q;
    last_d   = last_q;
    rd_go    = 1'b0;
    case (state_q)
      StIdle: begin
        gnt_d = 2'b00;
        if (pick != 2'b00) begin
          gnt_d   = pick;
          burst_d = '0;
          state_d = StServe;
        end
      end
      StServe: begin
        rd_go = req[owner] & ~blocked & ~rst;
        if (rd_go) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          burst_d  = burst_inc;
        end
        if (~req[owner] | blocked | (rd_go & (burst_inc == MaxBurstV))) begin
          state_d = StIdle;
          gnt_d   = 2'b00;
          last_d  = owner;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gnt_q     <= 2'b00;
      rd_ptr_q  <= '0;
      burst_q   <= '0;
      last_q    <= 1'b1;
      valid_q   <= 2'b00;
      ptr_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rd_ptr_q  <= rd_ptr_d;
      burst_q   <= burst_d;
      last_q    <= last_d;
      valid_q   <= {2{rd_go}} & gnt_q;
      ptr_err_q <= ptr_err_q | over;
    end
  end

  assign gnt     = gnt_q;
  assign rd_en   = rd_go;
  assign rd_addr = rd_ptr_q[PTR_W-2:0];
  assign rd_ptr  = rd_ptr_q;
  assign valid   = valid_q;
  assign ptr_err = ptr_err_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
module tb_fifo_rd_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] wr_ptr_sync = '0;
  logic [1:0] req = '0;
  logic [1:0] gnt, valid;
  logic       rd_en, empty, ptr_err;
  logic [7:0] rd_addr;
  logic [8:0] rd_ptr, level;

  always #5 clk = ~clk;

  fifo_rd_arbiter #(.PTR_W(9), .MAX_BURST(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_ptr_sync (wr_ptr_sync),
    .req         (req),
    .gnt         (gnt),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_ptr      (rd_ptr),
    .valid       (valid),
    .empty       (empty),
    .level       (level),
    .ptr_err     (ptr_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit armed  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Port owner (-1 when nobody holds it), reads served in the current grant,
  // last owner, read pointer and sticky error, all as plain integers.
  typedef struct {int owner; int addr; int stamp;} exp_t;
  exp_t sbq[$];
  int m_owner = -1, m_served = 0, m_last = 1, m_rp = 0, m_err = 0;

  function automatic int m_level();
    return (int'(wr_ptr_sync) - m_rp + 512) % 512;
  endfunction

  function automatic bit m_blocked();
    int l = m_level();
    return (l == 0) || (l > 256);
  endfunction

  function automatic bit m_rd();
    if (rst || m_owner < 0) return 1'b0;
    return req[m_owner] && !m_blocked();
  endfunction

  function automatic int m_gnt();
    return (m_owner < 0) ? 0 : (1 << m_owner);
  endfunction

  task automatic model_step();
    bit r;
    int l, o;
    r = m_rd();
    l = m_level();
    if (rst) begin
      m_owner = -1; m_served = 0; m_last = 1; m_rp = 0; m_err = 0;
      armed = 1;
    end else begin
      if (l > 256) m_err = 1;
      if (m_owner < 0) begin
        if (!(l == 0 || l > 256) && req != 2'b00) begin
          if (req == 2'b11) m_owner = 1 - m_last;
          else              m_owner = req[0] ? 0 : 1;
          m_served = 0;
        end
      end else begin
        o = m_owner;
        if (r) begin
          sbq.push_back('{o, m_rp % 256, cyc});
          m_rp = (m_rp + 1) % 512;
          m_served++;
        end
        if (!req[o] || l == 0 || l > 256 || (r && m_served == 4)) begin
          m_last  = o;
          m_owner = -1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  // ---------------- monitor / scoreboard ----------------
  int prev_addr = 0;

  task automatic monitor();
    exp_t e;
    chk("gnt", gnt, m_gnt());
    chk("rd_en", rd_en, m_rd());
    chk("rd_ptr", rd_ptr, m_rp);
    chk("level", level, m_level());
    chk("empty", empty, m_level() == 0);
    chk("ptr_err", ptr_err, m_err);
    if (valid != 2'b00) begin
      if (sbq.size() == 0) begin
        chk("valid_unexpected", valid, 0);
      end else begin
        e = sbq.pop_front();
        chk("valid_owner", valid, 1 << e.owner);
        chk("valid_cycle", cyc, e.stamp);
        chk("valid_addr", prev_addr, e.addr);
      end
    end else begin
      while (sbq.size() > 0 && sbq[0].stamp <= cyc) begin
        e = sbq.pop_front();
        chk("valid_missing", valid, 1 << e.owner);
      end
    end
    prev_addr = rd_addr;
  endtask

  initial forever begin
    @(negedge clk);
    if (armed) monitor();
  end

  // ---------------- stimulus ----------------
  task automatic drv_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  logic [1:0] gseq[$];
  int         rcnt[$];
  int         addrs[$];
  logic [1:0] pg;
  int         nrd;

  initial begin
    // Reset then single requester
    rst = 1'b1; wr_ptr_sync = 9'd3; req = 2'b01;
    drv_edge(); rst = 1'b0;
    smp();
    chk("rst_gnt", gnt, 0);
    chk("rst_rd_ptr", rd_ptr, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ptr_err", ptr_err, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_level", level, 3);
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("s1_gnt", gnt, 1);
      chk("s1_rd_en", rd_en, 1);
      chk("s1_addr", rd_addr, i);
      chk("s1_valid", valid, (i == 0) ? 0 : 1);
    end
    smp();
    chk("s1_last_valid", valid, 1);
    chk("s1_no_read", rd_en, 0);
    smp();
    chk("s1_empty", empty, 1);
    chk("s1_gnt_idle", gnt, 0);
    chk("s1_rd_ptr", rd_ptr, 3);

    // Contention: 20 entries, both requesting, requester 1 first
    drv_edge(); wr_ptr_sync = 9'd23; req = 2'b11;
    pg = 2'b00; nrd = 0;
    for (int i = 0; i < 80 && !(rd_ptr == 9'd23 && gnt == 2'b00); i++) begin
      smp();
      if (gnt != 2'b00 && pg == 2'b00) begin
        gseq.push_back(gnt);
        rcnt.push_back(0);
      end
      if (rd_en) begin
        nrd++;
        if (rcnt.size() > 0) rcnt[rcnt.size()-1]++;
      end
      pg = gnt;
    end
    chk("s2_rd_ptr", rd_ptr, 23);
    chk("s2_reads", nrd, 20);
    chk("s2_grants", gseq.size(), 5);
    foreach (gseq[i]) begin
      chk("s2_alternate", gseq[i], (i % 2 == 0) ? 2 : 1);
      chk("s2_burst_len", rcnt[i], 4);
    end
    chk("s2_empty", empty, 1);

    // Early release by requester 0 after two reads
    drv_edge(); wr_ptr_sync = 9'd33; req = 2'b11;
    for (int i = 0; i < 10 && gnt == 2'b00; i++) smp();
    chk("s3_gnt0", gnt, 1);
    chk("s3_read1", rd_en, 1);
    drv_edge(); smp();
    chk("s3_read2", rd_en, 1);
    drv_edge(); req = 2'b10;
    smp();
    chk("s3_release_no_read", rd_en, 0);
    smp();
    chk("s3_idle", gnt, 0);
    chk("s3_rd_ptr", rd_ptr, 25);
    smp();
    chk("s3_gnt1", gnt, 2);
    for (int i = 0; i < 40 && rd_ptr != 9'd33; i++) smp();
    chk("s3_drain", rd_ptr, 33);

    // Wrap-around: walk the read pointer to 510, then wr pointer to 1
    drv_edge(); req = 2'b01;
    for (int i = 0; i < 900 && m_rp != 510; i++) begin
      wr_ptr_sync = 9'((m_rp + 100 > 510) ? 510 : m_rp + 100);
      drv_edge();
    end
    smp();
    chk("s4_preload", rd_ptr, 510);
    drv_edge(); wr_ptr_sync = 9'd1;
    smp();
    chk("s4_level", level, 3);
    for (int i = 0; i < 20; i++) begin
      if (rd_en) addrs.push_back(int'(rd_addr));
      if (rd_ptr == 9'd1) break;
      smp();
    end
    chk("s4_nreads", addrs.size(), 3);
    if (addrs.size() == 3) begin
      chk("s4_addr0", addrs[0], 254);
      chk("s4_addr1", addrs[1], 255);
      chk("s4_addr2", addrs[2], 0);
    end
    chk("s4_rd_ptr", rd_ptr, 1);
    chk("s4_empty", empty, 1);
    chk("s4_ptr_err", ptr_err, 0);

    // Pointer error, then full level is legal
    drv_edge(); rst = 1'b1; req = 2'b11; wr_ptr_sync = 9'd300;
    drv_edge(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("s5_no_read", rd_en, 0);
      chk("s5_no_gnt", gnt, 0);
    end
    chk("s5_ptr_err", ptr_err, 1);
    chk("s5_level", level, 300);
    drv_edge(); wr_ptr_sync = 9'd256;
    smp();
    chk("s5_full_level", level, 256);
    smp(); smp(); smp();
    chk("s5_sticky", ptr_err, 1);
    chk("s5_full_reads", int'(rd_ptr != 9'd0), 1);
    drv_edge(); rst = 1'b1;
    drv_edge(); rst = 1'b0;
    smp();
    chk("s5_cleared", ptr_err, 0);

    // Reset mid-burst
    drv_edge(); rst = 1'b1; req = 2'b01; wr_ptr_sync = 9'd10;
    drv_edge(); rst = 1'b0;
    for (int i = 0; i < 10 && gnt == 2'b00; i++) smp();
    chk("s6_first_read", rd_en, 1);
    drv_edge(); rst = 1'b1;
    smp();
    chk("s6_rst_no_read", rd_en, 0);
    drv_edge(); rst = 1'b0; req = 2'b11;
    smp();
    chk("s6_rd_ptr", rd_ptr, 0);
    chk("s6_gnt", gnt, 0);
    chk("s6_valid", valid, 0);
    smp();
    chk("s6_first_owner", gnt, 1);

    // Randomized traffic, level kept legal
    for (int i = 0; i < 1500; i++) begin
      drv_edge();
      if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1 && m_level() + 3 <= 256)
        wr_ptr_sync = wr_ptr_sync + 9'($urandom_range(0, 3));
      rst = ($urandom_range(0, 299) == 0);
      if (rst) wr_ptr_sync = 9'($urandom_range(0, 200));
    end
    drv_edge(); rst = 1'b0; req = 2'b00;
    smp(); smp(); smp();
    chk("sb_drain", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
